// File: rtl/compressed_fetch_buffer_pkg.sv
// fetch_pkg: shared types for the compressed fetch buffer and its parcel queue
package fetch_pkg;
    typedef enum logic [1:0] {FS_IDLE, FS_WAIT, FS_DROP} fetch_state_e;
    typedef logic [15:0] parcel_t;
    typedef struct packed {
        parcel_t     hw;
        logic [31:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/compressed_fetch_buffer_if.sv
// compressed_fetch_buffer_if: instruction-memory read port, redirect input and decoder handshake
interface compressed_fetch_buffer_if;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemAck;
    logic [31:0] MemRData;
    logic        Redirect;
    logic [31:0] RedirectPc;
    logic [15:0] InstrOut;
    logic [31:0] InstrPc;
    logic        InstrValid;
    logic        InstrReady;
    modport master (
        output MemReq, MemAddr, InstrOut, InstrPc, InstrValid,
        input  MemAck, MemRData, Redirect, RedirectPc, InstrReady
    );
    modport slave (
        input  MemReq, MemAddr, InstrOut, InstrPc, InstrValid,
        output MemAck, MemRData, Redirect, RedirectPc, InstrReady
    );
endinterface

// File: rtl/compressed_fetch_buffer_queue.sv
// fetch_parcel_queue: circular parcel buffer, push 0-2 / pop 0-1 per cycle, synchronous flush
module fetch_parcel_queue import fetch_pkg::*; #(
    parameter int DEPTH = 4,
    parameter fetch_entry_t RST_ENTRY = '0,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic [1:0]   pushN,
    input  fetch_entry_t pushA,
    input  fetch_entry_t pushB,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);
    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= RST_ENTRY;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushN != 2'd0) mem[wrPtr] <= pushA;
            if (pushN == 2'd2) mem[wrPtr + AW'(1)] <= pushB;
            wrPtr <= wrPtr + AW'(pushN);
            rdPtr <= rdPtr + AW'(pop);
            count <= count + CW'(pushN) - CW'(pop);
        end
    end
    assign head = mem[rdPtr];
endmodule

// File: rtl/compressed_fetch_buffer.sv
// compressed_fetch_buffer: word fetch FSM feeding 16-bit parcels to the compressed decoder.
// Define FETCH_BYPASS_EN to present the first parcel of a response combinationally when the queue is empty.
module compressed_fetch_buffer import fetch_pkg::*; #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          BUF_HW   = 4
) (
    input logic clk,
    input logic rst_n,
    compressed_fetch_buffer_if.master bus
);
    localparam int CW = $clog2(BUF_HW) + 1;
    localparam fetch_entry_t RST_ENTRY = '{hw: 16'h0, pc: RESET_PC};
    fetch_state_e state, nextState;
    logic [31:0] fetchPc, wordPc, reqAddr;
    logic [CW-1:0] count;
    fetch_entry_t head, loEntry, hiEntry, firstEntry, pushA;
    logic odd, accept, issue, bypass, bypassPop, pop;
    logic [1:0] pushN;

    assign wordPc     = fetchPc & ~32'h3;
    assign odd        = fetchPc[1];
    assign loEntry    = '{hw: bus.MemRData[15:0], pc: reqAddr};
    assign hiEntry    = '{hw: bus.MemRData[31:16], pc: reqAddr + 32'd2};
    assign firstEntry = odd ? hiEntry : loEntry;
    assign accept     = state == FS_WAIT && bus.MemAck && !bus.Redirect;
    assign issue      = state == FS_IDLE && !bus.Redirect && int'(count) + 2 <= BUF_HW;
`ifdef FETCH_BYPASS_EN
    assign bypass     = accept && count == '0;
`else
    assign bypass     = 1'b0;
`endif
    assign bypassPop  = bypass && bus.InstrReady;
    // a bypassed parcel taken by the decoder never enters the queue
    assign pushN      = accept ? (odd ? 2'd1 : 2'd2) - {1'b0, bypassPop} : 2'd0;
    assign pushA      = bypassPop ? hiEntry : firstEntry;
    assign pop        = count != '0 && bus.InstrReady && !bus.Redirect;

    fetch_parcel_queue #(.DEPTH(BUF_HW), .RST_ENTRY(RST_ENTRY)) queue (
        .clk(clk), .rst_n(rst_n), .flush(bus.Redirect), .pushN(pushN),
        .pushA(pushA), .pushB(hiEntry), .pop(pop), .head(head), .count(count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FS_IDLE;
        else state <= nextState;
    end

    always_comb begin
        nextState = state == FS_IDLE ? (issue ? FS_WAIT : FS_IDLE)
                  : bus.MemAck ? FS_IDLE
                  : bus.Redirect ? FS_DROP : state;
    end

    always_comb begin
        bus.MemReq     = state != FS_IDLE;
        bus.MemAddr    = reqAddr;
        bus.InstrValid = count != '0 || bypass;
        bus.InstrOut   = bypass ? firstEntry.hw : head.hw;
        bus.InstrPc    = bypass ? firstEntry.pc : head.pc;
    end

    // reqAddr only moves on issue, so a redirect while a request is pending leaves MemAddr alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetchPc <= RESET_PC;
            reqAddr <= RESET_PC & ~32'h3;
        end else begin
            if (bus.Redirect) fetchPc <= bus.RedirectPc & ~32'h1;
            else if (accept) fetchPc <= wordPc + 32'd4;
            if (issue) reqAddr <= wordPc;
        end
    end
endmodule

// File: tb/tb_compressed_fetch_buffer.sv
// tb_compressed_fetch_buffer: directed scenarios for compressed_fetch_buffer with a latency-programmable memory
module tb_compressed_fetch_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    compressed_fetch_buffer_if bus();
    compressed_fetch_buffer_if bus2();
    compressed_fetch_buffer #(.RESET_PC(32'h0000_0000), .BUF_HW(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    compressed_fetch_buffer #(.RESET_PC(32'hFFFF_FFFC), .BUF_HW(4)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int vectors = 0, miscompares = 0, ackDelay = 1, waitCnt = 0, waitCnt2 = 0, reqCnt = 0;
    logic [47:0] got[$], got2[$];
    logic [31:0] ackAddrs[$], ackAddrs2[$];
    logic [47:0] expStream [6] = '{{16'h5555, 32'h0}, {16'hAAAA, 32'h2}, {16'h3333, 32'h4},
                                   {16'hCCCC, 32'h6}, {16'h0008, 32'h8}, {16'h000A, 32'hA}};

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a == 32'h0 ? 32'hAAAA_5555 : a == 32'h4 ? 32'hCCCC_3333 : {a[15:0] + 16'd2, a[15:0]};
    endfunction

    initial begin
        bus.MemAck = 1'b0;
        bus.MemRData = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n || bus.MemAck) begin
                bus.MemAck = 1'b0;
                waitCnt = 0;
            end else if (bus.MemReq) begin
                if (waitCnt >= ackDelay) begin
                    bus.MemAck = 1'b1;
                    bus.MemRData = memWord(bus.MemAddr);
                    ackAddrs.push_back(bus.MemAddr);
                    reqCnt++;
                end else waitCnt++;
            end
        end
    end

    initial begin
        bus2.MemAck = 1'b0;
        bus2.MemRData = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n || bus2.MemAck) begin
                bus2.MemAck = 1'b0;
                waitCnt2 = 0;
            end else if (bus2.MemReq) begin
                if (waitCnt2 >= 1) begin
                    bus2.MemAck = 1'b1;
                    bus2.MemRData = memWord(bus2.MemAddr);
                    ackAddrs2.push_back(bus2.MemAddr);
                end else waitCnt2++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus.InstrValid && bus.InstrReady && !bus.Redirect) got.push_back({bus.InstrOut, bus.InstrPc});
        if (rst_n && bus2.InstrValid && bus2.InstrReady && !bus2.Redirect) got2.push_back({bus2.InstrOut, bus2.InstrPc});
    end

    task automatic doReset;
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.Redirect = 1'b0;
        bus2.Redirect = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        got.delete(); got2.delete(); ackAddrs.delete(); ackAddrs2.delete();
        reqCnt = 0;
        rst_n = 1'b1;
    endtask

    task automatic waitGot(input bit second, input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if ((second ? got2.size() : got.size()) >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset;
        bus.InstrReady = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++; if (bus.MemReq !== 1'b0) begin miscompares++; $display("FAIL reset_memreq: got %b expected 0", bus.MemReq); end
        vectors++; if (bus.MemAddr !== 32'h0) begin miscompares++; $display("FAIL reset_memaddr: got %h expected 0", bus.MemAddr); end
        vectors++; if (bus.InstrValid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", bus.InstrValid); end
        vectors++; if (bus.InstrOut !== 16'h0) begin miscompares++; $display("FAIL reset_instr: got %h expected 0", bus.InstrOut); end
        vectors++; if (bus.InstrPc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h expected 0", bus.InstrPc); end
        vectors++; if (bus2.MemAddr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL reset_memaddr2: got %h expected fffffffc", bus2.MemAddr); end
        vectors++; if (bus2.InstrPc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL reset_pc2: got %h expected fffffffc", bus2.InstrPc); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (bus.MemReq !== 1'b0) begin miscompares++; $display("FAIL reset_noreq_before_edge: got %b expected 0", bus.MemReq); end
        @(negedge clk);
        vectors++; if (bus.MemReq !== 1'b1) begin miscompares++; $display("FAIL reset_first_req: got %b expected 1", bus.MemReq); end
    endtask

    task automatic test_stream;
        bit ok;
        bus.InstrReady = 1'b1;
        ackDelay = 1;
        doReset();
        @(negedge clk);
        @(negedge clk);
        vectors++; if (bus.MemReq !== 1'b1 || bus.MemAddr !== 32'h0) begin miscompares++; $display("FAIL stream_first_addr: got req=%b addr=%h expected req=1 addr=0", bus.MemReq, bus.MemAddr); end
        waitGot(1'b0, 6, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL stream_timeout: got %0d parcels expected 6", got.size()); end
        for (int i = 0; i < 6; i++) begin
            vectors++; if (got[i] !== expStream[i]) begin miscompares++; $display("FAIL stream_parcel%0d: got %h expected %h", i, got[i], expStream[i]); end
        end
    endtask

    task automatic test_backpressure;
        bit ok, captured;
        int unstable;
        logic [47:0] held;
        bus.InstrReady = 1'b0;
        ackDelay = 1;
        captured = 1'b0;
        unstable = 0;
        held = '0;
        doReset();
        repeat (10) begin
            @(negedge clk);
            if (bus.InstrValid && !captured) begin captured = 1'b1; held = {bus.InstrOut, bus.InstrPc}; end
            else if (captured && (!bus.InstrValid || {bus.InstrOut, bus.InstrPc} !== held)) unstable++;
        end
        vectors++; if (reqCnt !== 2) begin miscompares++; $display("FAIL bp_requests: got %0d expected 2", reqCnt); end
        vectors++; if (bus.MemReq !== 1'b0) begin miscompares++; $display("FAIL bp_memreq_idle: got %b expected 0", bus.MemReq); end
        vectors++; if (unstable !== 0) begin miscompares++; $display("FAIL bp_head_stable: got %0d changes expected 0", unstable); end
        vectors++; if ({bus.InstrOut, bus.InstrPc} !== expStream[0]) begin miscompares++; $display("FAIL bp_head: got %h expected %h", {bus.InstrOut, bus.InstrPc}, expStream[0]); end
        @(posedge clk); #1;
        bus.InstrReady = 1'b1;
        waitGot(1'b0, 6, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL bp_timeout: got %0d parcels expected 6", got.size()); end
        for (int i = 0; i < 6; i++) begin
            vectors++; if (got[i] !== expStream[i]) begin miscompares++; $display("FAIL bp_parcel%0d: got %h expected %h", i, got[i], expStream[i]); end
        end
    endtask

    task automatic test_redirect_idle;
        bit ok;
        bus.InstrReady = 1'b0;
        ackDelay = 1;
        doReset();
        repeat (10) @(posedge clk);
        #1;
        bus.Redirect = 1'b1;
        bus.RedirectPc = 32'h0000_0102;
        @(posedge clk); #1;
        bus.Redirect = 1'b0;
        bus.InstrReady = 1'b1;
        @(negedge clk);
        vectors++; if (bus.InstrValid !== 1'b0) begin miscompares++; $display("FAIL redir_idle_flush: got %b expected 0", bus.InstrValid); end
        waitGot(1'b0, 2, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL redir_idle_timeout: got %0d parcels expected 2", got.size()); end
        vectors++; if (ackAddrs[2] !== 32'h100) begin miscompares++; $display("FAIL redir_idle_addr: got %h expected 100", ackAddrs[2]); end
        vectors++; if (got[0] !== {16'h0102, 32'h102}) begin miscompares++; $display("FAIL redir_idle_p0: got %h expected 0102_00000102", got[0]); end
        vectors++; if (got[1] !== {16'h0104, 32'h104}) begin miscompares++; $display("FAIL redir_idle_p1: got %h expected 0104_00000104", got[1]); end
    endtask

    task automatic test_redirect_wait;
        bit ok;
        bus.InstrReady = 1'b1;
        ackDelay = 3;
        doReset();
        @(posedge clk); #1;
        bus.Redirect = 1'b1;
        bus.RedirectPc = 32'h0000_0040;
        @(posedge clk); #1;
        bus.Redirect = 1'b0;
        @(negedge clk);
        vectors++; if (bus.MemReq !== 1'b1 || bus.MemAddr !== 32'h0) begin miscompares++; $display("FAIL redir_wait_hold: got req=%b addr=%h expected req=1 addr=0", bus.MemReq, bus.MemAddr); end
        waitGot(1'b0, 2, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL redir_wait_timeout: got %0d parcels expected 2", got.size()); end
        vectors++; if (ackAddrs[1] !== 32'h40) begin miscompares++; $display("FAIL redir_wait_addr: got %h expected 40", ackAddrs[1]); end
        vectors++; if (got[0] !== {16'h0040, 32'h40}) begin miscompares++; $display("FAIL redir_wait_p0: got %h expected 0040_00000040", got[0]); end
        vectors++; if (got[1] !== {16'h0042, 32'h42}) begin miscompares++; $display("FAIL redir_wait_p1: got %h expected 0042_00000042", got[1]); end
    endtask

    task automatic test_wrap;
        bit ok;
        bus2.InstrReady = 1'b1;
        doReset();
        waitGot(1'b1, 3, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL wrap_timeout: got %0d parcels expected 3", got2.size()); end
        vectors++; if (got2[0] !== {16'hFFFC, 32'hFFFF_FFFC}) begin miscompares++; $display("FAIL wrap_p0: got %h expected fffc_fffffffc", got2[0]); end
        vectors++; if (got2[1] !== {16'hFFFE, 32'hFFFF_FFFE}) begin miscompares++; $display("FAIL wrap_p1: got %h expected fffe_fffffffe", got2[1]); end
        vectors++; if (got2[2] !== {16'h5555, 32'h0}) begin miscompares++; $display("FAIL wrap_p2: got %h expected 5555_00000000", got2[2]); end
        vectors++; if (ackAddrs2[1] !== 32'h0) begin miscompares++; $display("FAIL wrap_addr: got %h expected 0", ackAddrs2[1]); end
        bus2.InstrReady = 1'b0;
    endtask

    task automatic test_reset_mid;
        bus.InstrReady = 1'b0;
        ackDelay = 4;
        doReset();
        for (int i = 0; i < 40 && ackAddrs.size() == 0; i++) begin
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (bus.MemReq !== 1'b1 || bus.InstrValid !== 1'b1) begin miscompares++; $display("FAIL mid_precond: got req=%b valid=%b expected 1 1", bus.MemReq, bus.InstrValid); end
        ackDelay = 1;
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.MemReq !== 1'b0 || bus.InstrValid !== 1'b0) begin miscompares++; $display("FAIL mid_async: got req=%b valid=%b expected 0 0", bus.MemReq, bus.InstrValid); end
        vectors++; if ({bus.InstrOut, bus.InstrPc, bus.MemAddr} !== 80'h0) begin miscompares++; $display("FAIL mid_values: got %h expected 0", {bus.InstrOut, bus.InstrPc, bus.MemAddr}); end
        @(posedge clk); #1;
        got.delete();
        ackAddrs.delete();
        rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
`ifdef FETCH_BYPASS_EN
        vectors++; if (bus.InstrValid !== 1'b1 || bus.InstrOut !== 16'h5555) begin miscompares++; $display("FAIL mid_bypass: got valid=%b instr=%h expected 1 5555", bus.InstrValid, bus.InstrOut); end
`else
        vectors++; if (bus.InstrValid !== 1'b0) begin miscompares++; $display("FAIL mid_ackcycle: got valid=%b expected 0", bus.InstrValid); end
`endif
        @(negedge clk);
        vectors++; if ({bus.InstrValid, bus.InstrOut, bus.InstrPc} !== {1'b1, 16'h5555, 32'h0}) begin miscompares++; $display("FAIL mid_restart: got %h expected 1_5555_00000000", {bus.InstrValid, bus.InstrOut, bus.InstrPc}); end
        vectors++; if (ackAddrs[0] !== 32'h0) begin miscompares++; $display("FAIL mid_restart_addr: got %h expected 0", ackAddrs[0]); end
    endtask

    initial begin
        bus.Redirect = 1'b0;
        bus.RedirectPc = '0;
        bus.InstrReady = 1'b0;
        bus2.Redirect = 1'b0;
        bus2.RedirectPc = '0;
        bus2.InstrReady = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_idle();
        test_redirect_wait();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
